// File: rtl/gp_register_file_pkg.sv
// Shared definitions for the general-purpose register file: register indices,
// REP sequencer state encoding and string-step size decoding.
package gp_reg_pkg;

    localparam int EAX_IDX = 0;
    localparam int ECX_IDX = 1;
    localparam int EDX_IDX = 2;
    localparam int EBX_IDX = 3;
    localparam int ESP_IDX = 4;
    localparam int EBP_IDX = 5;
    localparam int ESI_IDX = 6;
    localparam int EDI_IDX = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rep_state_t;

    localparam logic [1:0] STEP_BYTE  = 2'd0;
    localparam logic [1:0] STEP_WORD  = 2'd1;
    localparam logic [1:0] STEP_DWORD = 2'd2;
    localparam logic [1:0] STEP_RSVD  = 2'd3;

    // The reserved encoding behaves as a word step.
    function automatic logic [2:0] step_bytes(input logic [1:0] size);
        case (size)
            STEP_BYTE:  return 3'd1;
            STEP_DWORD: return 3'd4;
            default:    return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/gp_register_file_rep_sequencer.sv
// REP string sequencer: IDLE/RUN/DONE FSM with latched step size and direction,
// producing a per-cycle step enable for the ESI/EDI/ECX registers.
module rep_sequencer
    import gp_reg_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       rep_start,
    input  logic       rep_abort,
    input  logic       step_ready,
    input  logic [1:0] step_size,
    input  logic       direction,
    input  logic       ecx_zero,
    input  logic       ecx_one,
    output logic       rep_busy,
    output logic       rep_done,
    output logic       step_en,
    output logic       step_dec,
    output logic [2:0] step_amount
);

    rep_state_t state;
    logic [1:0] size_q;
    logic       dir_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            size_q   <= 2'd0;
            dir_q    <= 1'b0;
            rep_busy <= 1'b0;
            rep_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rep_start) begin
                    size_q   <= step_size;
                    dir_q    <= direction;
                    state    <= ecx_zero ? DONE : RUN;
                    rep_busy <= !ecx_zero;
                    rep_done <= ecx_zero;
                end
                // Abort and an already-empty count both finish without a step.
                RUN: if (rep_abort || ecx_zero || (step_ready && ecx_one)) begin
                    state    <= DONE;
                    rep_busy <= 1'b0;
                    rep_done <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    rep_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    rep_busy <= 1'b0;
                    rep_done <= 1'b0;
                end
            endcase
        end
    end

    assign step_en     = (state == RUN) && step_ready && !rep_abort && !ecx_zero;
    assign step_dec    = dir_q;
    assign step_amount = step_bytes(size_q);

endmodule

// File: rtl/gp_register_file.sv
// Parametrised general-purpose register file with one write port, two
// combinational read ports and a REP string sequencer stepping ESI/EDI/ECX.
// Optional same-cycle write-to-read forwarding: define GP_REG_READ_BYPASS_EN.
module gp_register_file
    import gp_reg_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter logic [NUM_REGS*WIDTH-1:0] RESET_VALUES =
        ({{(NUM_REGS*WIDTH-WIDTH){1'b0}}, WIDTH'(32'h0000_0888)} << (EDI_IDX*WIDTH)) |
        ({{(NUM_REGS*WIDTH-WIDTH){1'b0}}, WIDTH'(32'h0000_0F00)} << (ESP_IDX*WIDTH))
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [IDX_W-1:0] write_index,
    input  logic [WIDTH-1:0] write_data,
    input  logic [IDX_W-1:0] read_index_a,
    output logic [WIDTH-1:0] read_data_a,
    input  logic [IDX_W-1:0] read_index_b,
    output logic [WIDTH-1:0] read_data_b,
    input  logic             rep_start,
    input  logic             rep_abort,
    input  logic             step_ready,
    input  logic [1:0]       step_size,
    input  logic             direction,
    output logic             rep_busy,
    output logic             rep_done,
    output logic [WIDTH-1:0] esi,
    output logic [WIDTH-1:0] edi,
    output logic [WIDTH-1:0] ecx
);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic             step_en;
    logic             step_dec;
    logic [2:0]       step_amount;
    logic [WIDTH-1:0] delta;

    rep_sequencer u_rep_sequencer (
        .clock       (clock),
        .reset       (reset),
        .rep_start   (rep_start),
        .rep_abort   (rep_abort),
        .step_ready  (step_ready),
        .step_size   (step_size),
        .direction   (direction),
        .ecx_zero    (regs[ECX_IDX] == '0),
        .ecx_one     (regs[ECX_IDX] == WIDTH'(1)),
        .rep_busy    (rep_busy),
        .rep_done    (rep_done),
        .step_en     (step_en),
        .step_dec    (step_dec),
        .step_amount (step_amount)
    );

    assign delta = WIDTH'(step_amount);

    // The external write is applied last so it wins over a same-cycle step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= RESET_VALUES[i*WIDTH +: WIDTH];
        end else begin
            if (step_en) begin
                regs[ESI_IDX] <= step_dec ? regs[ESI_IDX] - delta : regs[ESI_IDX] + delta;
                regs[EDI_IDX] <= step_dec ? regs[EDI_IDX] - delta : regs[EDI_IDX] + delta;
                regs[ECX_IDX] <= regs[ECX_IDX] - WIDTH'(1);
            end
            if (write_enable)
                regs[write_index] <= write_data;
        end
    end

`ifdef GP_REG_READ_BYPASS_EN
    assign read_data_a = (write_enable && write_index == read_index_a) ? write_data : regs[read_index_a];
    assign read_data_b = (write_enable && write_index == read_index_b) ? write_data : regs[read_index_b];
`else
    assign read_data_a = regs[read_index_a];
    assign read_data_b = regs[read_index_b];
`endif

    assign esi = regs[ESI_IDX];
    assign edi = regs[EDI_IDX];
    assign ecx = regs[ECX_IDX];

endmodule

// File: tb/tb_gp_register_file.sv
// Self-checking bench for gp_register_file: vector tables, REP corner-case
// sequences and a randomized run against a behavioural model.
module tb_gp_register_file;
    import gp_reg_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        write_enable = 1'b0;
    logic [2:0]  write_index = '0;
    logic [31:0] write_data = '0;
    logic [2:0]  read_index_a = '0;
    logic [31:0] read_data_a;
    logic [2:0]  read_index_b = '0;
    logic [31:0] read_data_b;
    logic        rep_start = 1'b0;
    logic        rep_abort = 1'b0;
    logic        step_ready = 1'b0;
    logic [1:0]  step_size = '0;
    logic        direction = 1'b0;
    logic        rep_busy, rep_done;
    logic [31:0] esi, edi, ecx;

    int checks = 0;
    int failures = 0;

    gp_register_file dut (
        .clock(clock), .reset(reset),
        .write_enable(write_enable), .write_index(write_index), .write_data(write_data),
        .read_index_a(read_index_a), .read_data_a(read_data_a),
        .read_index_b(read_index_b), .read_data_b(read_data_b),
        .rep_start(rep_start), .rep_abort(rep_abort), .step_ready(step_ready),
        .step_size(step_size), .direction(direction),
        .rep_busy(rep_busy), .rep_done(rep_done),
        .esi(esi), .edi(edi), .ecx(ecx)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [2:0]  widx;
        logic [31:0] wdata;
        logic [2:0]  ridx;
        logic [31:0] exp;
    } wr_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int idx, input logic [31:0] data);
        write_enable = 1'b1;
        write_index  = 3'(idx);
        write_data   = data;
        tick();
        write_enable = 1'b0;
    endtask

    logic [31:0] rm [8];
    int          mst;      // 0 idle, 1 running, 2 finishing
    int          msz;
    logic        mdec;

    initial begin
        rd_vec_t rst_tab [8];
        wr_vec_t wr_tab [5];
        int k;
        logic [31:0] exp_a, exp_b;

        rst_tab = '{'{3'd0, 32'h0}, '{3'd1, 32'h0}, '{3'd2, 32'h0}, '{3'd3, 32'h0},
                    '{3'd4, 32'h0000_0F00}, '{3'd5, 32'h0}, '{3'd6, 32'h0}, '{3'd7, 32'h0000_0888}};
        wr_tab  = '{'{3'd0, 32'hAAAA_5555, 3'd0, 32'hAAAA_5555},
                    '{3'd3, 32'h1234_5678, 3'd0, 32'hAAAA_5555},
                    '{3'd5, 32'hCAFE_F00D, 3'd5, 32'hCAFE_F00D},
                    '{3'd4, 32'h0,         3'd4, 32'h0},
                    '{3'd7, 32'hFFFF_FFFF, 3'd7, 32'hFFFF_FFFF}};

        #12 reset = 1'b0;
        tick();

        // Reset values on both read ports
        for (int i = 0; i < 8; i++) begin
            read_index_a = rst_tab[i].idx;
            read_index_b = rst_tab[i].idx;
            #1;
            chk($sformatf("reset_a[%0d]", i), read_data_a, rst_tab[i].exp);
            chk($sformatf("reset_b[%0d]", i), read_data_b, rst_tab[i].exp);
        end
        chk("reset_busy", {31'b0, rep_busy}, 32'h0);
        chk("reset_done", {31'b0, rep_done}, 32'h0);

        // Write then read next cycle
        for (int i = 0; i < 5; i++) begin
            read_index_b = wr_tab[i].ridx;
            wr(wr_tab[i].widx, wr_tab[i].wdata);
            #1;
            chk($sformatf("wr_vec[%0d]", i), read_data_b, wr_tab[i].exp);
        end

        // 3 dword steps forward; size/dir changed after start must not matter
        wr(ESI_IDX, 32'h100); wr(EDI_IDX, 32'h200); wr(ECX_IDX, 32'd3);
        step_size = 2'd2; direction = 1'b0; step_ready = 1'b1; rep_start = 1'b1;
        tick();
        rep_start = 1'b0; step_size = 2'd0; direction = 1'b1;
        k = 1;
        while (!rep_done && k < 10) begin tick(); k++; end
        chk("seq1_done_cycle", k, 32'd4);
        chk("seq1_esi", esi, 32'h10C);
        chk("seq1_edi", edi, 32'h20C);
        chk("seq1_ecx", ecx, 32'h0);
        step_ready = 1'b0;
        tick();
        chk("seq1_done_pulse", {31'b0, rep_done}, 32'h0);

        // Byte decrement wrap with a mid-run stall
        wr(ESI_IDX, 32'h0); wr(EDI_IDX, 32'h10); wr(ECX_IDX, 32'd2);
        step_size = 2'd0; direction = 1'b1; rep_start = 1'b1;
        tick();
        rep_start = 1'b0; step_ready = 1'b1;
        tick();
        step_ready = 1'b0;
        repeat (3) tick();
        chk("seq2_stall_esi", esi, 32'hFFFF_FFFF);
        chk("seq2_stall_ecx", ecx, 32'h1);
        chk("seq2_stall_busy", {31'b0, rep_busy}, 32'h1);
        step_ready = 1'b1;
        tick();
        step_ready = 1'b0;
        chk("seq2_esi", esi, 32'hFFFF_FFFE);
        chk("seq2_edi", edi, 32'h0000_000E);
        chk("seq2_ecx", ecx, 32'h0);
        chk("seq2_done", {31'b0, rep_done}, 32'h1);
        tick();

        // Start with ECX already zero
        wr(ESI_IDX, 32'h77);
        rep_start = 1'b1;
        tick();
        rep_start = 1'b0;
        chk("seq3_done", {31'b0, rep_done}, 32'h1);
        chk("seq3_busy", {31'b0, rep_busy}, 32'h0);
        chk("seq3_esi", esi, 32'h77);
        tick();
        chk("seq3_done_clear", {31'b0, rep_done}, 32'h0);

        // Abort beats a same-cycle step
        wr(ECX_IDX, 32'd5);
        rep_start = 1'b1;
        tick();
        rep_start = 1'b0; rep_abort = 1'b1; step_ready = 1'b1;
        tick();
        rep_abort = 1'b0; step_ready = 1'b0;
        chk("seq4_done", {31'b0, rep_done}, 32'h1);
        chk("seq4_ecx", ecx, 32'd5);
        chk("seq4_esi", esi, 32'h77);
        tick();

        // External EDI write during a step
        wr(ESI_IDX, 32'h10); wr(EDI_IDX, 32'h20); wr(ECX_IDX, 32'd2);
        step_size = 2'd1; direction = 1'b0; rep_start = 1'b1;
        tick();
        rep_start = 1'b0; step_ready = 1'b1;
        write_enable = 1'b1; write_index = 3'(EDI_IDX); write_data = 32'h5000;
        tick();
        write_enable = 1'b0; step_ready = 1'b0;
        chk("seq5_edi", edi, 32'h5000);
        chk("seq5_esi", esi, 32'h12);
        chk("seq5_ecx", ecx, 32'h1);
        rep_abort = 1'b1;
        tick();
        rep_abort = 1'b0;
        tick();

        // Asynchronous reset in the middle of a run
        wr(ECX_IDX, 32'd5); wr(ESI_IDX, 32'h40);
        step_size = 2'd0; step_ready = 1'b1; rep_start = 1'b1;
        tick();
        rep_start = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        read_index_a = 3'(ESP_IDX);
        #1;
        chk("midrst_esi", esi, 32'h0);
        chk("midrst_edi", edi, 32'h0000_0888);
        chk("midrst_ecx", ecx, 32'h0);
        chk("midrst_esp", read_data_a, 32'h0000_0F00);
        chk("midrst_busy", {31'b0, rep_busy}, 32'h0);
        reset = 1'b0; step_ready = 1'b0;
        tick();
        chk("midrst_idle", {31'b0, rep_busy}, 32'h0);

        // Same-cycle read of a register being written
        wr(EAX_IDX, 32'h11);
        read_index_a = 3'(EAX_IDX);
        write_enable = 1'b1; write_index = 3'(EAX_IDX); write_data = 32'hDEAD_BEEF;
        #1;
`ifdef GP_REG_READ_BYPASS_EN
        chk("bypass_same", read_data_a, 32'hDEAD_BEEF);
`else
        chk("nobypass_same", read_data_a, 32'h11);
`endif
        tick();
        write_enable = 1'b0;
        #1;
        chk("bypass_next", read_data_a, 32'hDEAD_BEEF);

        // Randomized run against the behavioural model
        reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 8; i++) rm[i] = 32'h0;
        rm[ESP_IDX] = 32'h0000_0F00;
        rm[EDI_IDX] = 32'h0000_0888;
        mst = 0; msz = 1; mdec = 1'b0;
        tick();
        for (int c = 0; c < 400; c++) begin
            logic step;
            int   nst;
            write_enable = ($urandom_range(0, 3) == 0);
            write_index  = 3'($urandom_range(0, 7));
            write_data   = (write_index == 3'(ECX_IDX)) ? 32'($urandom_range(0, 4)) : $urandom;
            rep_start    = ($urandom_range(0, 3) == 0);
            rep_abort    = ($urandom_range(0, 15) == 0);
            step_ready   = 1'($urandom_range(0, 1));
            step_size    = 2'($urandom_range(0, 3));
            direction    = 1'($urandom_range(0, 1));
            read_index_a = 3'($urandom_range(0, 7));
            read_index_b = 3'($urandom_range(0, 7));
            #1;
            exp_a = rm[read_index_a];
            exp_b = rm[read_index_b];
`ifdef GP_REG_READ_BYPASS_EN
            if (write_enable && write_index == read_index_a) exp_a = write_data;
            if (write_enable && write_index == read_index_b) exp_b = write_data;
`endif
            chk("rnd_read_a", read_data_a, exp_a);
            chk("rnd_read_b", read_data_b, exp_b);

            step = (mst == 1) && step_ready && !rep_abort && (rm[ECX_IDX] != 0);
            nst = mst;
            if (mst == 0) begin
                if (rep_start) begin
                    msz  = (step_size == 2'd0) ? 1 : (step_size == 2'd2) ? 4 : 2;
                    mdec = direction;
                    nst  = (rm[ECX_IDX] == 0) ? 2 : 1;
                end
            end else if (mst == 1) begin
                if (rep_abort || rm[ECX_IDX] == 0 || (step && rm[ECX_IDX] == 1)) nst = 2;
            end else begin
                nst = 0;
            end
            if (step) begin
                rm[ESI_IDX] = mdec ? rm[ESI_IDX] - 32'(msz) : rm[ESI_IDX] + 32'(msz);
                rm[EDI_IDX] = mdec ? rm[EDI_IDX] - 32'(msz) : rm[EDI_IDX] + 32'(msz);
                rm[ECX_IDX] = rm[ECX_IDX] - 32'd1;
            end
            if (write_enable) rm[write_index] = write_data;
            mst = nst;

            tick();
            chk("rnd_esi", esi, rm[ESI_IDX]);
            chk("rnd_edi", edi, rm[EDI_IDX]);
            chk("rnd_ecx", ecx, rm[ECX_IDX]);
            chk("rnd_busy", {31'b0, rep_busy}, {31'b0, mst == 1});
            chk("rnd_done", {31'b0, rep_done}, {31'b0, mst == 2});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gp_register_file.md
Name: gp_register_file

Overview:
- Parametrised general-purpose register file that replaces the per-register blocks.
- Holds NUM_REGS registers of WIDTH bits, with one write port and two combinational read ports.
- Adds a REP string-operation sequencer: it auto-steps ESI/EDI by ±1/2/4 bytes and counts ECX down to zero, handshaking with the memory stage.
- Sits between decode/execute and the memory/string unit.

Parameters:
- WIDTH, 32, register width in bits.
- NUM_REGS, 8, number of registers; must be a power of two and at least 8.
- IDX_W, $clog2(NUM_REGS), register index width.
- RESET_VALUES, {NUM_REGS*WIDTH}, packed per-register reset values; register i occupies bits [i*WIDTH +: WIDTH]. Default is 0 for all except ESP=32'h0000_0F00 and EDI=32'h0000_0888.

Ports:
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- write_enable  in  1  write strobe
- write_index  in  IDX_W  register written
- write_data  in  WIDTH  write value
- read_index_a  in  IDX_W  read port A select
- read_data_a  out  WIDTH  read port A data
- read_index_b  in  IDX_W  read port B select
- read_data_b  out  WIDTH  read port B data
- rep_start  in  1  begin REP sequence (accepted only in IDLE)
- rep_abort  in  1  terminate sequence (accepted in RUN)
- step_ready  in  1  memory stage has completed one element this cycle
- step_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = treated as 2
- direction  in  1  0 = increment, 1 = decrement (DF)
- rep_busy  out  1  high in RUN
- rep_done  out  1  one-cycle pulse on completion or abort
- esi, edi, ecx  out  WIDTH  direct register taps

Behaviour:
- Reset (asynchronous, any time including mid-sequence):
  - every register takes its RESET_VALUES slice;
  - FSM goes to IDLE;
  - rep_busy=0 and rep_done=0;
  - the latched step_size and direction are cleared to 0.
- Write: on posedge with write_enable=1, reg[write_index] <= write_data. New value is visible on read ports the next cycle.
- Reads: read_data_x = reg[read_index_x] combinationally. esi, edi and ecx are continuous taps of their registers.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on rep_start. step_size and direction are latched at this edge.
  - IDLE -> DONE if ecx==0 at rep_start; no step occurs.
  - RUN, step_ready=1:
    - esi and edi each change by ±size; ecx <= ecx-1.
    - All arithmetic is modulo 2^WIDTH; 0 - 4 gives 32'hFFFF_FFFC.
    - If ecx was 1 (post-step 0) -> DONE.
  - RUN, step_ready=0: hold; no update.
  - RUN with ecx==0 (for example after an external write of 0): -> DONE without stepping.
  - RUN with rep_abort=1: -> DONE; abort wins over a same-cycle step_ready, so no step occurs.
  - DONE: rep_done=1 for exactly one cycle, then -> IDLE.
- rep_start while RUN or DONE is ignored.
- Simultaneous write and step:
  - the external write wins for the register it targets;
  - the other stepped registers still update.
- A write of ECX in the same cycle as the final step leaves ECX equal to write_data and still goes to DONE.
- Latency: one step per accepted step_ready cycle. An N-element sequence with step_ready held high gives rep_done N+1 cycles after rep_start.

Optional Feature:
- Macro: GP_REG_READ_BYPASS_EN.
- Defined: if write_enable=1 and write_index equals read_index_x, read_data_x returns write_data in the same cycle. Stepped ESI/EDI/ECX values are not bypassed.
- Undefined: reads always return the stored value, with no forwarding.

Decomposition:
- Package gp_reg_pkg holds:
  - index constants EAX_IDX=0, ECX_IDX=1, EDX_IDX=2, EBX_IDX=3, ESP_IDX=4, EBP_IDX=5, ESI_IDX=6, EDI_IDX=7;
  - the rep_state_t enum (IDLE/RUN/DONE);
  - the step_size encoding constants;
  - a function converting step_size to a byte count.
- One natural sub-module, rep_sequencer. It holds the FSM plus the latched size and direction, and outputs per-cycle step enables to the storage array.

Test Plan:
- Reset with no writes -> read EDI=32'h0000_0888, ESP=32'h0000_0F00, others 0; rep_busy=0. Assert reset mid-RUN -> same values immediately, FSM IDLE.
- ESI=0x100, EDI=0x200, ECX=3; rep_start with size=2 (4B), dir=0; step_ready held high -> ESI=0x10C, EDI=0x20C, ECX=0; rep_done pulses on cycle 4 after start.
- ECX=2, dir=1, size=0, ESI=0 -> after two steps ESI=32'hFFFF_FFFE (wrap). step_ready low for 3 cycles mid-run -> no change during the stall.
- ECX=0 then rep_start -> rep_done next cycle, no register change. rep_abort together with step_ready in RUN -> no step, rep_done pulses.
- Write EDI=0x5000 in the same cycle as a step -> EDI=0x5000; ESI and ECX still step.
- With GP_REG_READ_BYPASS_EN: write EAX=0xDEADBEEF while read_index_a=0 -> read_data_a=0xDEADBEEF the same cycle. Without the macro -> old value that cycle, new value the next.
